// File: rtl/pose_pkg.sv
// Shared types and constants for the pose commit stage.
// A pose is the translate/scale/rotation bundle handed from the
// switch-driven input stage to the transform-matrix builder.
package pose_pkg;

    localparam int TRANSLATE_W = 9;
    localparam int ROT_W       = 5;
    localparam int SCALE_W     = 32;

    // IEEE-754 single precision 1.0
    localparam logic [SCALE_W-1:0] SCALE_ONE = 32'h3F80_0000;

    // translate[0] occupies the least significant bits of the packed vector
    typedef struct packed {
        logic [2:0][TRANSLATE_W-1:0] translate;
        logic [SCALE_W-1:0]          scale;
        logic [ROT_W-1:0]            pitch;
        logic [ROT_W-1:0]            roll;
        logic [ROT_W-1:0]            yaw;
    } pose_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_COMMIT,
        ST_HOLD
    } state_t;

    // Reset pose: everything zero except the scale, which starts at the
    // caller-chosen value so the renderer never sees a degenerate scale.
    function automatic pose_t pose_reset_value(input logic [SCALE_W-1:0] scale);
        pose_t p;
        p       = '0;
        p.scale = scale;
        return p;
    endfunction

endpackage

// File: rtl/frame_step_timer.sv
// Frame pacing for the pose commit stage. Counts vblank pulses seen while
// the stage is idle and decides whether a pulse triggers the one-off
// initial commit, a step of the input stage, or just advances the count.
module frame_step_timer #(
    parameter int STEP_FRAMES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_start,
    input  logic idle,
    output logic init_go,
    output logic step_go,
    output logic step_valid
);

    localparam int FRAME_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(STEP_FRAMES - 1);

    logic [FRAME_W-1:0] frame_cnt;
    logic               init_pending;
    logic               frame_seen;

    assign frame_seen = idle && frame_start;
    assign init_go    = frame_seen && init_pending;
    assign step_go    = frame_seen && !init_pending && (frame_cnt == FRAME_LAST);

    // The first accepted frame after reset only publishes the reset pose;
    // later frames count up and every STEP_FRAMES-th one emits a step pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt    <= '0;
            init_pending <= 1'b1;
            step_valid   <= 1'b0;
        end else begin
            step_valid <= step_go;
            if (init_go) begin
                init_pending <= 1'b0;
            end else if (step_go) begin
                frame_cnt <= '0;
            end else if (frame_seen) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pose_commit_stage.sv
// Pose commit stage: paces the input stage with step pulses, holds the
// working pose that is fed back to it, and after each step publishes a
// frame-stable snapshot of that pose over a valid/ready handshake.
module pose_commit_stage
    import pose_pkg::*;
#(
    parameter int          STEP_FRAMES   = 2,
    parameter int          SETTLE_CYCLES = 16,
    parameter logic [31:0] SCALE_RESET   = 32'h3F80_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        frame_start_in,
    output logic        step_valid_out,
    input  logic [26:0] translate_in,
    input  logic [4:0]  pitch_in,
    input  logic [4:0]  roll_in,
    input  logic [4:0]  yaw_in,
    input  logic [31:0] scale_in,
    input  logic        scale_valid_in,
    output logic [26:0] current_translate_out,
    output logic [31:0] current_scale_out,
    output logic [4:0]  current_pitch_out,
    output logic [4:0]  current_roll_out,
    output logic [4:0]  current_yaw_out,
    output logic [26:0] pose_translate_out,
    output logic [31:0] pose_scale_out,
    output logic [4:0]  pose_pitch_out,
    output logic [4:0]  pose_roll_out,
    output logic [4:0]  pose_yaw_out,
    output logic        pose_valid_out,
    input  logic        pose_ready_in,
    output logic [7:0]  overrun_cnt_out
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    state_t              state;
    logic [SETTLE_W-1:0] settle_cnt;
    pose_t               work_pose;
    pose_t               commit_pose;
    logic                pose_valid;
    logic [7:0]          overrun_cnt;
    logic                idle;
    logic                init_go;
    logic                step_go;
    logic                settle_done;

    assign idle        = (state == ST_IDLE);
    assign settle_done = (state == ST_SETTLE) && (settle_cnt == SETTLE_LAST);

    frame_step_timer #(
        .STEP_FRAMES(STEP_FRAMES)
    ) u_frame_step_timer (
        .clk        (clk_in),
        .rst_n      (rst_in),
        .frame_start(frame_start_in),
        .idle       (idle),
        .init_go    (init_go),
        .step_go    (step_go),
        .step_valid (step_valid_out)
    );

    // Sequencing: wait for a frame, let the input stage settle after a step,
    // snapshot the working pose, then hold it until the renderer takes it.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state       <= ST_IDLE;
            settle_cnt  <= '0;
            commit_pose <= pose_reset_value(SCALE_RESET);
            pose_valid  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (init_go) begin
                        state <= ST_COMMIT;
                    end else if (step_go) begin
                        settle_cnt <= '0;
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    commit_pose <= work_pose;
                    pose_valid  <= 1'b1;
                    state       <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (pose_valid && pose_ready_in) begin
                        pose_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Working pose: scale follows its strobe at any time, while translate and
    // rotation are sampled only once the input stage has had time to settle.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            work_pose <= pose_reset_value(SCALE_RESET);
        end else begin
            if (scale_valid_in) begin
                work_pose.scale <= scale_in;
            end
            if (settle_done) begin
                work_pose.translate <= translate_in;
                work_pose.pitch     <= pitch_in;
                work_pose.roll      <= roll_in;
                work_pose.yaw       <= yaw_in;
            end
        end
    end

    // Frames arriving while a step or handshake is in flight are lost; keep a
    // saturating tally of them for diagnostics.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            overrun_cnt <= '0;
        end else if (frame_start_in && !idle && (overrun_cnt != 8'hFF)) begin
            overrun_cnt <= overrun_cnt + 1'b1;
        end
    end

    assign current_translate_out = work_pose.translate;
    assign current_scale_out     = work_pose.scale;
    assign current_pitch_out     = work_pose.pitch;
    assign current_roll_out      = work_pose.roll;
    assign current_yaw_out       = work_pose.yaw;

    assign pose_translate_out = commit_pose.translate;
    assign pose_scale_out     = commit_pose.scale;
    assign pose_pitch_out     = commit_pose.pitch;
    assign pose_roll_out      = commit_pose.roll;
    assign pose_yaw_out       = commit_pose.yaw;
    assign pose_valid_out     = pose_valid;
    assign overrun_cnt_out    = overrun_cnt;

endmodule

// File: doc/pose_commit_stage.md
Name: pose_commit_stage

Overview:
Sits directly downstream of the switch-driven transform input stage and feeds the transform-matrix builder. It paces the input stage by issuing a one-cycle step pulse every STEP_FRAMES frames. It holds the working pose, which is fed back to the input stage as current_* values. After each step it commits a frame-stable pose snapshot to the renderer over a valid/ready handshake.

Parameters:
STEP_FRAMES, 2, frame_start_in pulses per step pulse (>=1)
SETTLE_CYCLES, 16, cycles waited after a step before capture; must be >= float-adder latency + 2 (>=1)
SCALE_RESET, 32'h3F80_0000, IEEE-754 single reset scale (1.0)

Ports:
clk_in  input  1  system clock; all logic on posedge
rst_in  input  1  synchronous, active-low reset
frame_start_in  input  1  one-cycle pulse at vblank start
step_valid_out  output  1  one-cycle step pulse to input stage valid_in
translate_in  input  3x9  translate from input stage
pitch_in / roll_in / yaw_in  input  5 each  rotation indices from input stage
scale_in  input  32  float scale from input stage
scale_valid_in  input  1  scale_in update strobe
current_translate_out  output  3x9  working translate, fed back
current_scale_out  output  32  working scale, fed back
current_pitch_out / current_roll_out / current_yaw_out  output  5 each  working rotation, fed back
pose_translate_out  output  3x9  committed translate
pose_scale_out  output  32  committed scale
pose_pitch_out / pose_roll_out / pose_yaw_out  output  5 each  committed rotation
pose_valid_out  output  1  committed pose valid
pose_ready_in  input  1  downstream accepts pose
overrun_cnt_out  output  8  saturating count of frames missed while busy

Behaviour:
- Reset (rst_in==0 at posedge):
  - all translate/rotation regs (working and committed) = 0
  - working and committed scale = SCALE_RESET
  - step_valid_out = 0, pose_valid_out = 0, overrun_cnt_out = 0
  - frame_cnt = 0, settle_cnt = 0, init_pending = 1, state = IDLE
  - Reset mid-operation abandons any step or handshake immediately.
- Working regs:
  - Working scale loads scale_in on any cycle with scale_valid_in, in any state.
  - Working translate/rotation load from the inputs only on the final SETTLE cycle.
  - current_* outputs are the working regs directly.
- FSM states: IDLE, SETTLE, COMMIT, HOLD.
- IDLE, on frame_start_in:
  - If init_pending: clear init_pending, go COMMIT. No step and no frame_cnt change.
  - Else if frame_cnt==STEP_FRAMES-1: frame_cnt<=0, step_valid_out<=1 for exactly one cycle, settle_cnt<=0, go SETTLE.
  - Else: frame_cnt++.
- SETTLE: settle_cnt++ each cycle. When settle_cnt==SETTLE_CYCLES-1, capture translate/rotation and go COMMIT.
- COMMIT (one cycle):
  - Copy the working regs to the pose_* regs and set pose_valid_out<=1; go HOLD.
  - A scale_valid_in in this same cycle updates working scale only; it reaches pose on the next commit.
- HOLD:
  - pose_* and pose_valid_out are held stable.
  - On pose_valid_out && pose_ready_in: pose_valid_out<=0, go IDLE.
  - pose_ready_in high early does not shorten latency.
- Latency (step path): frame_start_in sampled at edge T gives step_valid_out high in cycle T+1 and pose_valid_out high from cycle T+SETTLE_CYCLES+2.
- Busy frames: frame_start_in in any non-IDLE state does not advance frame_cnt. It increments overrun_cnt_out, saturating at 255.
- Values are passed through unmodified; no arithmetic on pose data. Wrap/modulo is the input stage's responsibility.

Decomposition:
- Package pose_pkg holds:
  - TRANSLATE_W=9, ROT_W=5, SCALE_W=32
  - SCALE_ONE=32'h3F80_0000
  - pose_t struct (translate[3], scale, pitch, roll, yaw)
  - state enum
- Internally the block uses pose_t registers.
- One natural sub-module: frame_step_timer. It owns frame_cnt, init_pending and step pulse generation, driven by frame_start_in and an idle qualifier from the FSM.

Test Plan:
- Reset, then first frame_start_in -> no step_valid_out; pose_valid_out rises 2 cycles later with scale 32'h3F800000 and all other fields 0; ready=1 clears valid next cycle.
- STEP_FRAMES=2, SETTLE_CYCLES=16, roll_in=3 before capture, 2 frames after init -> step_valid_out high exactly 1 cycle at T+1; pose_valid_out at T+18 with pose_roll_out=3.
- scale_valid_in with 32'h40000000 during SETTLE -> current_scale_out=32'h40000000 next cycle; committed pose_scale_out=32'h40000000.
- Hold pose_ready_in=0 for 50 cycles with 3 frame_start_in pulses -> pose_* stable, overrun_cnt_out=3, no step pulses; ready=1 returns to IDLE.
- 300 frame_start_in pulses while stalled -> overrun_cnt_out saturates at 255.
- rst_in=0 for one cycle during SETTLE -> step path aborted, all outputs at reset values, next frame_start_in performs init commit.
